// File: rtl/or_6_bit_reg.sv
// Registered bitwise-OR unit for the 6-bit CPU ALU.
// Produces a | b plus carry/sign/zero flags, captured on the load strobe
// and held until the next load or reset. valid pulses on each load edge.
module or_6_bit_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             cf,
  output logic             sf,
  output logic             zf,
  output logic             valid
);

  // Combinational result of the current operands; flags come from this,
  // never from the previously registered result.
  logic [WIDTH-1:0] w_or;
  logic             w_sign;
  logic             w_zero;

  // Result, flag and strobe registers.
  logic [WIDTH-1:0] r_c;
  logic             r_cf;
  logic             r_sf;
  logic             r_zf;
  logic             r_valid;

  // Per-bit OR of the two operands.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_bit
      assign w_or[gi] = a[gi] | b[gi];
    end
  endgenerate

  assign w_sign = w_or[WIDTH-1];
  assign w_zero = ~(|w_or);

  // Result and flags load together on an accepted edge and hold otherwise.
  // cf is a constant-0 bit kept only so the flag bus matches the adder units.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c  <= '0;
      r_cf <= 1'b0;
      r_sf <= 1'b0;
      r_zf <= 1'b1;
    end else if (en) begin
      r_c  <= w_or;
      r_cf <= 1'b0;
      r_sf <= w_sign;
      r_zf <= w_zero;
    end
  end

  // valid marks exactly the edges on which the result registers were loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
    end
  end

  assign c     = r_c;
  assign cf    = r_cf;
  assign sf    = r_sf;
  assign zf    = r_zf;
  assign valid = r_valid;

endmodule

// File: tb/tb_or_6_bit_reg.sv
// Directed bench for or_6_bit_reg: hand-computed vectors covering reset,
// load, hold, asynchronous reset mid-stream and back-to-back loads.
module tb_or_6_bit_reg;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             cf;
  logic             sf;
  logic             zf;
  logic             valid;

  int checks   = 0;
  int failures = 0;

  or_6_bit_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (a),
    .b     (b),
    .c     (c),
    .cf    (cf),
    .sf    (sf),
    .zf    (zf),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against hand-computed values, one line per transaction.
  task automatic check_all(input string tag, input logic [WIDTH-1:0] exp_c,
                           input logic exp_sf, input logic exp_zf,
                           input logic exp_valid);
    $display("%s: c=%b cf=%b sf=%b zf=%b valid=%b", tag, c, cf, sf, zf, valid);
    check_eq({tag, ".c"},     32'(c),     32'(exp_c));
    check_eq({tag, ".cf"},    32'(cf),    32'd0);
    check_eq({tag, ".sf"},    32'(sf),    32'(exp_sf));
    check_eq({tag, ".zf"},    32'(zf),    32'(exp_zf));
    check_eq({tag, ".valid"}, 32'(valid), 32'(exp_valid));
  endtask

  // Drive operands away from the active edge, then sample just after it.
  task automatic step(input logic i_en, input logic [WIDTH-1:0] i_a,
                      input logic [WIDTH-1:0] i_b);
    @(negedge clk);
    en = i_en;
    a  = i_a;
    b  = i_b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 6'b000000, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 6'b010101, 6'b001100);
    check_all("mixed", 6'b011101, 1'b0, 1'b0, 1'b1);

    step(1'b1, 6'b000000, 6'b000000);
    check_all("zero", 6'b000000, 1'b0, 1'b1, 1'b1);

    step(1'b1, 6'b111100, 6'b000000);
    check_all("msb", 6'b111100, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'b101010, 6'b010101);
      check_all($sformatf("hold%0d", i), 6'b111100, 1'b1, 1'b0, 1'b0);
    end

    step(1'b1, 6'b010101, 6'b001100);
    check_all("reload", 6'b011101, 1'b0, 1'b0, 1'b1);

    // Assert reset between edges and check it acts without a clock edge.
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 6'b000000, 1'b0, 1'b1, 1'b0);

    // Load request held during reset must be ignored.
    en = 1'b1;
    a  = 6'b111111;
    b  = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("rst_hold%0d", i), 6'b000000, 1'b0, 1'b1, 1'b0);
    end

    // First edge after release is a normal accept.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("release", 6'b111111, 1'b1, 1'b0, 1'b1);

    step(1'b1, 6'b000001, 6'b000010);
    check_all("b2b0", 6'b000011, 1'b0, 1'b0, 1'b1);

    step(1'b1, 6'b100000, 6'b000000);
    check_all("b2b1", 6'b100000, 1'b1, 1'b0, 1'b1);

    step(1'b0, 6'b000000, 6'b000000);
    check_all("idle", 6'b100000, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/or_6_bit_reg.md
Name: or_6_bit_reg

Overview:
- Registered 6-bit bitwise-OR unit of the 6-bit CPU ALU. It produces the result word plus carry, sign and zero flags.
- Operands are sampled on a load strobe. Result and flags are held in output registers until the next load or reset.
- The flag semantics match the CPU's other logic units:
  - OR never carries.
  - Sign is the result MSB.
  - Zero is set when the result is all zeros.

Parameters:
- WIDTH, 6, operand/result width in bits. The CPU uses 6; other values must work for WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  load strobe; operands are accepted on a rising clk edge when en=1
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  output  WIDTH  registered result, a | b
- cf  output  1  registered carry flag, always 0
- sf  output  1  registered sign flag, c[WIDTH-1]
- zf  output  1  registered zero flag, 1 when c == 0
- valid  output  1  one-cycle pulse marking that c and the flags were updated on this edge

Behaviour:
- Reset (rst=1, asynchronous, independent of clk):
  - c=0, cf=0, sf=0, zf=1 (flags are consistent with c=0), valid=0.
  - Outputs hold these values for as long as rst stays high.
- Release: the first edge after rst deasserts behaves as a normal edge. No extra wait cycles.
- Accept: rising clk edge with rst=0 and en=1:
  - c <= a | b (bitwise over all WIDTH bits)
  - cf <= 0
  - sf <= (a|b)[WIDTH-1]
  - zf <= 1 if (a|b) == 0, else 0
  - valid <= 1
- Idle: rising edge with en=0:
  - c, cf, sf, zf hold their previous values.
  - valid <= 0.
- Latency: exactly 1 clock from the en sample to the new c/flags. Throughput is one operation per cycle; back-to-back en=1 is allowed, and valid stays high on every such cycle.
- Operand changes while en=0 must not affect any output.
- Flags are computed from the combinational a|b of the same edge, never from the old c. c and the flags update atomically on the same edge.
- Reset mid-operation: reset asserted in the same cycle as en=1 wins. Outputs take reset values and that operation is discarded.
- No X propagation: every output has a defined value from reset onward.
- cf must be a constant-0 register bit, kept for flag-bus uniformity with the adder/subtractor units. It must never be driven from operands.

Test Plan:
- Mixed operands: rst pulse, then en=1, a=010101, b=001100 -> next edge c=011101, cf=0, sf=0, zf=0, valid=1.
- MSB set: en=1, a=111100, b=000000 -> c=111100, cf=0, sf=1, zf=0, valid=1.
- Zero result: en=1, a=000000, b=000000 -> c=000000, cf=0, sf=0, zf=1, valid=1.
- Hold: after c=111100, set en=0 and change a=101010, b=010101 for 3 cycles -> c stays 111100 with sf=1, zf=0 unchanged; valid=0 on each of those cycles.
- Async reset mid-stream:
  - With c=011101, assert rst between clock edges -> immediately c=0, zf=1, sf=0, cf=0, valid=0.
  - Hold en=1, a=111111 during reset -> outputs unchanged until release.
  - After release, the next edge gives c=111111, sf=1, zf=0.
- Back-to-back: en=1 for consecutive cycles with (a,b) = (000001,000010) then (100000,000000) -> c=000011 then 100000; sf=0 then 1; valid held at 1 both cycles.
